delay_list_mngr: RTL and testbench

- Parametrised delay list for the RTOS list manager. Holds up to DEPTH delayed tasks, each with an absolute wake-up tick.
- On every system tick it scans the list and releases expired task IDs through a valid/ready port. The ready-list inserter consumes them.
- Generalises the single fixed delay-list insert path to configurable depth, ID width and tick width. Adds cancel-by-ID, back-pressure and missed-tick detection.

---
 rtl/delay_list_mngr.sv | 215 +++++++++++++++++++++
 tb/tb_delay_list_mngr.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_list_mngr.sv
// delay_list_mngr: tick-driven delay list for the RTOS list manager.
// Holds up to DEPTH {id, absolute wake tick} entries. Each rising edge of tick_in
// triggers a slot-by-slot scan; expired IDs are released on a valid/ready port.
// Optional build macro DLYLIST_RELOAD_EN adds ins_period and periodic re-arm.
module delay_list_mngr #(
    parameter int DEPTH  = 16,
    parameter int ID_W   = 8,
    parameter int TICK_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [ID_W-1:0]   ins_id,
    input  logic [TICK_W-1:0] ins_delay,
`ifdef DLYLIST_RELOAD_EN
    input  logic [TICK_W-1:0] ins_period,
`endif
    input  logic              rem_valid,
    input  logic [ID_W-1:0]   rem_id,
    input  logic              tick_in,
    input  logic [TICK_W-1:0] tickval_in,
    output logic              wake_valid,
    input  logic              wake_ready,
    output logic [ID_W-1:0]   wake_id,
    output logic [CNT_W-1:0]  count_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              overflow_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_pending, w_pending_next;
    logic             r_ovf, w_ovf_next;
    logic             r_tick_d;
    logic             r_run;
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0]  r_vld;
    logic [ID_W-1:0]   r_id   [DEPTH];
    logic [TICK_W-1:0] r_wake [DEPTH];
`ifdef DLYLIST_RELOAD_EN
    logic [TICK_W-1:0] r_period [DEPTH];
`endif

    logic [DEPTH-1:0] w_free, w_match;
    logic [IDX_W-1:0] w_free_idx, w_rem_idx;
    logic             w_rem_hit;
    logic             w_edge, w_expired, w_rearm;
    logic             w_do_ins, w_do_rem, w_do_emit;

    assign w_edge       = tick_in && !r_tick_d;
    assign count_out    = r_count;
    assign full_out     = (r_count == CNT_W'(DEPTH));
    assign empty_out    = (r_count == '0);
    assign overflow_err = r_ovf;

    // Wrap-safe expiry: slot is due when (now - wake) is non-negative as a signed value.
    assign w_expired = r_vld[r_idx] &&
                       ($signed(tickval_in - r_wake[r_idx]) >= $signed(TICK_W'(0)));

`ifdef DLYLIST_RELOAD_EN
    assign w_rearm = (r_period[r_idx] != '0);
`else
    assign w_rearm = 1'b0;
`endif

    // Per-slot free / cancel-match flags.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_free[gi]  = !r_vld[gi];
            assign w_match[gi] = r_vld[gi] && (r_id[gi] == rem_id);
        end
    endgenerate

    // Lowest-index priority encoders for the insert slot and the cancel target.
    always_comb begin
        w_free_idx = '0;
        w_rem_idx  = '0;
        w_rem_hit  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_free_idx = IDX_W'(i);
            end
            if (w_match[i]) begin
                w_rem_idx = IDX_W'(i);
                w_rem_hit = 1'b1;
            end
        end
    end

    // Next-state, handshake outputs and slot-update strobes.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_pending_next = r_pending;
        w_ovf_next     = r_ovf;
        w_do_ins       = 1'b0;
        w_do_rem       = 1'b0;
        w_do_emit      = 1'b0;
        ins_ready      = 1'b0;
        wake_valid     = 1'b0;
        wake_id        = '0;
        case (r_state)
            IDLE: begin
                ins_ready = r_run && !full_out && !rem_valid && !w_edge && !r_pending;
                if (w_edge || r_pending) begin
                    w_state_next   = SCAN;
                    w_idx_next     = '0;
                    w_pending_next = 1'b0;
                end else if (rem_valid) begin
                    w_do_rem = w_rem_hit;
                end else if (ins_valid && ins_ready) begin
                    w_do_ins = 1'b1;
                end
            end
            SCAN: begin
                if (w_edge) begin
                    w_ovf_next     = r_ovf | r_pending;
                    w_pending_next = 1'b1;
                end
                if (w_expired) begin
                    w_state_next = EMIT;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = IDLE;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            EMIT: begin
                if (w_edge) begin
                    w_ovf_next     = r_ovf | r_pending;
                    w_pending_next = 1'b1;
                end
                wake_valid = 1'b1;
                wake_id    = r_id[r_idx];
                if (wake_ready) begin
                    w_do_emit = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = SCAN;
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
            r_tick_d  <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_pending <= w_pending_next;
            r_ovf     <= w_ovf_next;
            r_tick_d  <= tick_in;
            r_run     <= 1'b1;
        end
    end

    // Slot valid bits: set on insert, cleared on cancel or one-shot emit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vld <= '0;
        end else begin
            if (w_do_ins) r_vld[w_free_idx] <= 1'b1;
            if (w_do_rem) r_vld[w_rem_idx] <= 1'b0;
            if (w_do_emit && !w_rearm) r_vld[r_idx] <= 1'b0;
        end
    end

    // Slot payload; meaningful only while the matching valid bit is set.
    always_ff @(posedge aclk) begin
        if (w_do_ins) begin
            r_id[w_free_idx]   <= ins_id;
            r_wake[w_free_idx] <= tickval_in + ins_delay;
`ifdef DLYLIST_RELOAD_EN
            r_period[w_free_idx] <= ins_period;
`endif
        end
`ifdef DLYLIST_RELOAD_EN
        if (w_do_emit && w_rearm) begin
            r_wake[r_idx] <= r_wake[r_idx] + r_period[r_idx];
        end
`endif
    end

    // Occupancy counter; insert and removals never coincide (different states).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_count <= '0;
        end else if (w_do_ins) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_do_rem || (w_do_emit && !w_rearm)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_delay_list_mngr.sv
// Self-checking bench for delay_list_mngr (DEPTH=16, ID_W=8, TICK_W=32).
// Expected wake IDs are queued when a tick is driven and popped by a monitor
// on every wake handshake; unexpected or missing wakes are reported.
module tb_delay_list_mngr;
    localparam int DEPTH  = 16;
    localparam int ID_W   = 8;
    localparam int TICK_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              aclk;
    logic              aresetn;
    logic              ins_valid;
    logic              ins_ready;
    logic [ID_W-1:0]   ins_id;
    logic [TICK_W-1:0] ins_delay;
`ifdef DLYLIST_RELOAD_EN
    logic [TICK_W-1:0] ins_period;
`endif
    logic              rem_valid;
    logic [ID_W-1:0]   rem_id;
    logic              tick_in;
    logic [TICK_W-1:0] tickval_in;
    logic              wake_valid;
    logic              wake_ready;
    logic [ID_W-1:0]   wake_id;
    logic [CNT_W-1:0]  count_out;
    logic              full_out;
    logic              empty_out;
    logic              overflow_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [ID_W-1:0] sb[$];

    delay_list_mngr #(
        .DEPTH(DEPTH), .ID_W(ID_W), .TICK_W(TICK_W), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .ins_id(ins_id),
        .ins_delay(ins_delay),
`ifdef DLYLIST_RELOAD_EN
        .ins_period(ins_period),
`endif
        .rem_valid(rem_valid),
        .rem_id(rem_id),
        .tick_in(tick_in),
        .tickval_in(tickval_in),
        .wake_valid(wake_valid),
        .wake_ready(wake_ready),
        .wake_id(wake_id),
        .count_out(count_out),
        .full_out(full_out),
        .empty_out(empty_out),
        .overflow_err(overflow_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every handshake must match the oldest expected ID.
    always @(negedge aclk) begin
        if (aresetn && wake_valid && wake_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_wake_id", 32'(wake_id), 32'hFFFF_FFFF);
            end else begin
                chk("wake_id", 32'(wake_id), 32'(sb.pop_front()));
            end
            $display("wake handshake id=0x%0h t=%0t", wake_id, $time);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        repeat (DEPTH + 4) step();
    endtask

    task automatic insert(input logic [ID_W-1:0] id, input logic [TICK_W-1:0] dly);
        int waited;
        ins_valid = 1'b1;
        ins_id    = id;
        ins_delay = dly;
        waited    = 0;
        @(negedge aclk);
        while (!ins_ready && waited < 40) begin
            @(negedge aclk);
            waited++;
        end
        if (waited >= 40) chk("insert_timeout", 32'(ins_ready), 32'd1);
        step();
        ins_valid = 1'b0;
        $display("insert id=0x%0h delay=0x%0h tick=0x%0h", id, dly, tickval_in);
    endtask

    task automatic pulse(input logic [TICK_W-1:0] val);
        tickval_in = val;
        tick_in    = 1'b1;
        step();
        tick_in    = 1'b0;
        step();
        $display("tick edge tickval=0x%0h", val);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) step();
        chk("drain_left", 32'(sb.size()), 32'd0);
        settle();
    endtask

    task automatic remove(input logic [ID_W-1:0] id);
        rem_valid = 1'b1;
        rem_id    = id;
        step();
        rem_valid = 1'b0;
        step();
        $display("remove id=0x%0h", id);
    endtask

    initial begin
        aresetn    = 1'b0;
        ins_valid  = 1'b0;
        ins_id     = '0;
        ins_delay  = '0;
`ifdef DLYLIST_RELOAD_EN
        ins_period = '0;
`endif
        rem_valid  = 1'b0;
        rem_id     = '0;
        tick_in    = 1'b0;
        tickval_in = '0;
        wake_ready = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_ins_ready", 32'(ins_ready), 32'd0);
        chk("rst_wake_valid", 32'(wake_valid), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        aresetn = 1'b1;
        step();
        step();
        chk("post_rst_ins_ready", 32'(ins_ready), 32'd1);

        // Basic expiry: wakes at 0x15 (id 1) and 0x08 (id 2)
        tickval_in = 32'h05;
        insert(8'd1, 32'h10);
        insert(8'd2, 32'h03);
        step();
        chk("basic_count2", 32'(count_out), 32'd2);
        pulse(32'h07);
        settle();
        chk("basic_early_count", 32'(count_out), 32'd2);
        sb.push_back(8'd2);
        pulse(32'h08);
        drain(60);
        chk("basic_count1", 32'(count_out), 32'd1);
        sb.push_back(8'd1);
        pulse(32'h15);
        drain(60);
        chk("basic_count0", 32'(count_out), 32'd0);
        chk("basic_empty", 32'(empty_out), 32'd1);

        // Delay 0 wakes at the next edge
        tickval_in = 32'h20;
        insert(8'd5, 32'h0);
        step();
        chk("d0_count", 32'(count_out), 32'd1);
        sb.push_back(8'd5);
        pulse(32'h20);
        drain(60);
        chk("d0_count0", 32'(count_out), 32'd0);

        // Wrap-around: wake = 0xFFFFFFFE + 4 = 0x00000002
        tickval_in = 32'hFFFF_FFFE;
        insert(8'd7, 32'd4);
        pulse(32'hFFFF_FFFF);
        settle();
        pulse(32'h0000_0000);
        settle();
        chk("wrap_still_held", 32'(count_out), 32'd1);
        sb.push_back(8'd7);
        pulse(32'h0000_0002);
        drain(60);
        chk("wrap_count0", 32'(count_out), 32'd0);

        // Full list and back-pressure, plus missed-tick detection
        wake_ready = 1'b0;
        tickval_in = 32'h100;
        for (int i = 0; i < DEPTH; i++) insert(ID_W'(i), 32'd1);
        step();
        chk("full_count", 32'(count_out), 32'(DEPTH));
        chk("full_flag", 32'(full_out), 32'd1);
        ins_valid = 1'b1;
        ins_id    = 8'h55;
        ins_delay = 32'd1;
        @(negedge aclk);
        chk("full_ins_ready", 32'(ins_ready), 32'd0);
        repeat (3) step();
        ins_valid = 1'b0;
        step();
        chk("full_no_insert", 32'(count_out), 32'(DEPTH));
        pulse(32'h101);
        for (int i = 0; i < 30 && !wake_valid; i++) step();
        chk("bp_wake_valid", 32'(wake_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_hold_id", 32'(wake_id), 32'd0);
            chk("bp_hold_valid", 32'(wake_valid), 32'd1);
        end
        step();
        pulse(32'h101);
        chk("ovf_after_first", 32'(overflow_err), 32'd0);
        pulse(32'h101);
        chk("ovf_after_second", 32'(overflow_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) sb.push_back(ID_W'(i));
        wake_ready = 1'b1;
        drain(200);
        chk("drain_count0", 32'(count_out), 32'd0);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Cancel priority over insert; absent ID has no effect
        tickval_in = 32'h200;
        insert(8'd3, 32'd5);
        insert(8'd10, 32'd5);
        step();
        chk("cancel_count2", 32'(count_out), 32'd2);
        rem_valid = 1'b1;
        rem_id    = 8'd3;
        ins_valid = 1'b1;
        ins_id    = 8'd11;
        ins_delay = 32'd5;
        @(negedge aclk);
        chk("cancel_ins_blocked", 32'(ins_ready), 32'd0);
        step();
        rem_valid = 1'b0;
        ins_valid = 1'b0;
        step();
        chk("cancel_count1", 32'(count_out), 32'd1);
        remove(8'd9);
        chk("cancel_absent", 32'(count_out), 32'd1);
        sb.push_back(8'd10);
        pulse(32'h205);
        drain(60);
        chk("cancel_count0", 32'(count_out), 32'd0);

`ifdef DLYLIST_RELOAD_EN
        // Periodic re-arm: delay 2, period 3 -> wakes at +2, +5, +8
        tickval_in = 32'h300;
        ins_period = 32'd3;
        insert(8'd4, 32'd2);
        ins_period = 32'd0;
        for (int t = 1; t <= 9; t++) begin
            if (t == 2 || t == 5 || t == 8) sb.push_back(8'd4);
            pulse(32'h300 + 32'(t));
            drain(60);
            chk("reload_count", 32'(count_out), 32'd1);
        end
        remove(8'd4);
        chk("reload_removed", 32'(count_out), 32'd0);
`endif

        // Asynchronous reset while an emission is stalled
        wake_ready = 1'b0;
        tickval_in = 32'h400;
        insert(8'd6, 32'd0);
        pulse(32'h400);
        for (int i = 0; i < 30 && !wake_valid; i++) step();
        chk("mid_emit_valid", 32'(wake_valid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("async_wake_valid", 32'(wake_valid), 32'd0);
        chk("async_count", 32'(count_out), 32'd0);
        chk("async_empty", 32'(empty_out), 32'd1);
        chk("async_ovf", 32'(overflow_err), 32'd0);
        step();
        aresetn = 1'b1;
        step();
        step();
        chk("rerelease_ins_ready", 32'(ins_ready), 32'd1);
        chk("rerelease_wake_valid", 32'(wake_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
